// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter sharing one 8-bit Fibonacci LFSR among NREQ requesters.
// Each grant advances the LFSR STEPS times; the last issued byte drives a 2-digit hex display.
module lfsr_rng_arbiter #(
  parameter int NREQ  = 4,
  parameter int STEPS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seed_valid,
  input  logic [7:0]      seed_data,
  output logic            seed_ready,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            rnd_valid,
  output logic [7:0]      rnd_data,
  output logic            busy,
  output logic [13:0]     seg_hex
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_GRANT = 2'd2;

  logic [1:0]    state;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_next;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] winner;
  logic [CW-1:0] cnt;
  logic [PW-1:0] win_idx;
  logic          win_found;

  assign lfsr_next  = {lfsr[4] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0], lfsr[7:1]};
  assign seed_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);

  // First asserted request at or after rr_ptr, wrapping past NREQ-1.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    win_found = 1'b0;
    win_idx   = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = int'(rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!win_found && req[k]) begin
        win_found = 1'b1;
        win_idx   = PW'(k);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= 8'h01;
      rr_ptr    <= '0;
      winner    <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (seed_valid) begin
            lfsr <= (seed_data == 8'h00) ? 8'h01 : seed_data;
          end else if (win_found) begin
            winner <= win_idx;
            cnt    <= CW'(STEPS - 1);
            state  <= S_STEP;
          end
        end
        S_STEP: begin
          lfsr <= lfsr_next;
          if (cnt == '0) begin
            rnd_data  <= lfsr_next;
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            rnd_valid <= 1'b1;
            state     <= S_GRANT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_GRANT: begin
          gnt       <= '0;
          rnd_valid <= 1'b0;
          rr_ptr    <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Active-low glyphs, bit0 = segment a .. bit6 = segment g.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign seg_hex = {hex7(rnd_data[7:4]), hex7(rnd_data[3:0])};

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Randomized and directed bench for lfsr_rng_arbiter against a transaction-timeline model
// that predicts each grant's cycle, winner and byte at the moment the request is sampled.
module tb_lfsr_rng_arbiter;

  localparam int NREQ  = 4;
  localparam int STEPS = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            seed_valid = 1'b0;
  logic [7:0]      seed_data = 8'h00;
  logic            seed_ready;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [7:0]      rnd_data;
  logic            busy;
  logic [13:0]     seg_hex;

  lfsr_rng_arbiter #(.NREQ(NREQ), .STEPS(STEPS)) dut (
    .clk(clk), .rst(rst),
    .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
    .req(req), .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .busy(busy), .seg_hex(seg_hex)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

  // Model: one entry per outstanding grant, timed from the sampling cycle.
  int         cyc = 0;
  logic [7:0] m_lfsr = 8'h01;
  int         m_ptr = 0;
  int         m_next_idle = 0;
  int         m_gcyc = -1;
  int         m_gwin = 0;
  logic [7:0] m_gbyte = 8'h00;
  logic [7:0] m_rnd = 8'h00;

  logic [NREQ-1:0] req_hold = '0;
  logic            sv_hold = 1'b0;
  logic [7:0]      sd_hold = 8'h00;
  bit              drop_on_gnt = 1'b0;

  int g_cyc[$];
  int g_idx[$];

  task automatic tick();
    logic [NREQ-1:0] exp_gnt;
    bit idle;
    @(negedge clk);
    if (cyc == m_gcyc) m_rnd = m_gbyte;
    exp_gnt = (cyc == m_gcyc) ? NREQ'(1 << m_gwin) : '0;
    idle = (cyc >= m_next_idle);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("rnd_valid", 32'(rnd_valid), 32'(cyc == m_gcyc));
    check("rnd_data", 32'(rnd_data), 32'(m_rnd));
    check("seg_hex", 32'(seg_hex), 32'({glyph[m_rnd[7:4]], glyph[m_rnd[3:0]]}));
    check("busy", 32'(busy), 32'(!idle));
    check("seed_ready", 32'(seed_ready), 32'(idle));
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        g_cyc.push_back(cyc);
        g_idx.push_back(i);
      end
    end
    if (drop_on_gnt) req_hold = req_hold & ~exp_gnt;
    req        = req_hold;
    seed_valid = sv_hold;
    seed_data  = sd_hold;
    if (idle) begin
      if (sv_hold) begin
        m_lfsr = (sd_hold == 8'h00) ? 8'h01 : sd_hold;
      end else if (req_hold != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_hold[(m_ptr + i) % NREQ]) begin
            m_gwin = (m_ptr + i) % NREQ;
            break;
          end
        end
        for (int s = 0; s < STEPS; s++) m_lfsr = lfsr_adv(m_lfsr);
        m_gbyte     = m_lfsr;
        m_gcyc      = cyc + STEPS + 1;
        m_next_idle = cyc + STEPS + 2;
        m_ptr       = (m_gwin + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0; seed_valid = 1'b0;
    req_hold = '0; sv_hold = 1'b0; drop_on_gnt = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rnd_valid", 32'(rnd_valid), 32'h0);
    check("rst_rnd_data", 32'(rnd_data), 32'h00);
    check("rst_seg_hex", 32'(seg_hex), 32'({7'h40, 7'h40}));
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_lfsr = 8'h01; m_ptr = 0; m_gcyc = -1; m_rnd = 8'h00; m_next_idle = cyc;
    g_cyc.delete(); g_idx.delete();
  endtask

  int t0;

  initial begin
    // 1: single request from reset
    do_reset();
    t0 = cyc;
    req_hold = 4'b0001; tick(); req_hold = '0;
    run(STEPS + 2);
    check("t1_ngrants", 32'(g_cyc.size()), 32'd1);
    if (g_cyc.size() >= 1) check("t1_gnt_cycle", 32'(g_cyc[0] - t0), 32'(STEPS + 1));
    check("t1_rnd", 32'(rnd_data), 32'h71);
    check("t1_seg", 32'(seg_hex), 32'({7'h78, 7'h79}));

    // 2: second byte continues the sequence
    req_hold = 4'b0001; tick(); req_hold = '0;
    run(STEPS + 2);
    check("t2_rnd", 32'(rnd_data), 32'hA4);
    check("t2_seg", 32'(seg_hex), 32'({7'h08, 7'h19}));

    // 3: all requesting continuously
    do_reset();
    t0 = cyc;
    req_hold = 4'b1111;
    run(5 * (STEPS + 2));
    req_hold = '0;
    check("t3_ngrants", 32'(g_idx.size()), 32'd5);
    if (g_idx.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t3_order", 32'(g_idx[i]), 32'(i % NREQ));
        if (i > 0) check("t3_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(STEPS + 2));
      end
    end
    run(STEPS + 2);

    // 4: one-shot requesters drop req in their grant cycle
    do_reset();
    req_hold = 4'b1010; drop_on_gnt = 1'b1;
    run(4 * (STEPS + 2));
    drop_on_gnt = 1'b0;
    check("t4_ngrants", 32'(g_idx.size()), 32'd2);
    if (g_idx.size() >= 2) begin
      check("t4_first", 32'(g_idx[0]), 32'd1);
      check("t4_second", 32'(g_idx[1]), 32'd3);
    end
    check("t4_busy_low", 32'(busy), 32'h0);

    // 5a: zero seed becomes 8'h01
    sv_hold = 1'b1; sd_hold = 8'h00; tick(); sv_hold = 1'b0;
    req_hold = 4'b0001; tick(); req_hold = '0;
    run(STEPS + 2);
    check("t5a_rnd", 32'(rnd_data), 32'h71);

    // 5b: seed and request together -> grant one cycle later
    g_cyc.delete(); g_idx.delete();
    t0 = cyc;
    sv_hold = 1'b1; sd_hold = 8'h5A; req_hold = 4'b0100; tick();
    sv_hold = 1'b0; tick(); req_hold = '0;
    run(STEPS + 2);
    check("t5b_ngrants", 32'(g_cyc.size()), 32'd1);
    if (g_cyc.size() >= 1) check("t5b_gnt_cycle", 32'(g_cyc[0] - t0), 32'(STEPS + 2));

    // 5c: seed while busy is ignored
    req_hold = 4'b0001; tick(); req_hold = '0;
    sv_hold = 1'b1; sd_hold = 8'h33; run(3); sv_hold = 1'b0;
    run(STEPS);

    // 6: reset while STEP count is 3 (rr_ptr is nonzero beforehand)
    req_hold = 4'b0010; tick(); req_hold = '0;
    run(4);
    do_reset();
    run(2 * (STEPS + 2));
    check("t6_no_gnt", 32'(g_cyc.size()), 32'd0);
    req_hold = 4'b1111; tick(); req_hold = '0;
    run(STEPS + 2);
    check("t6_winner0", (g_idx.size() >= 1) ? 32'(g_idx[0]) : 32'hFFFF, 32'd0);
    check("t6_rnd", 32'(rnd_data), 32'h71);

    // Randomized traffic with occasional seeds
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req_hold = NREQ'($urandom);
      drop_on_gnt = ($urandom_range(0, 1) == 1);
      sv_hold = ($urandom_range(0, 7) == 0);
      sd_hold = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      tick();
    end
    sv_hold = 1'b0; req_hold = '0;
    run(STEPS + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
